// File: rtl/x3_writeback_unit_pkg.sv
// Shared encodings and constants for the X3 write-back unit.
// Holds load-width codes, the JAL link register, the SAD seed value and min-SAD FSM states.
// Pure declarations; no timing or flow-control behaviour.
package wb_pkg;

  localparam logic [1:0]  BITS_WORD = 2'b00;
  localparam logic [1:0]  BITS_HALF = 2'b01;
  localparam logic [1:0]  BITS_BYTE = 2'b10;

  localparam logic [4:0]  JAL_REG   = 5'd31;
  localparam logic [31:0] SAD_INIT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sad_state_e;

endpackage

// File: rtl/x3_writeback_unit_sad_min4.sv
// Combinational minimum of four SAD lanes plus the winning lane number.
// Latency 0 (pure combinational).
// No flow control; on equal values the lower-numbered lane wins.
module sad_min4 (
  input  logic [31:0] lane0,
  input  logic [31:0] lane1,
  input  logic [31:0] lane2,
  input  logic [31:0] lane3,
  output logic [31:0] min_val,
  output logic [1:0]  min_lane
);

  logic [31:0] m01, m23;
  logic [1:0]  i01, i23;

  // Two-level tree; strict less-than keeps the lower lane on ties at every level.
  always_comb begin
    m01 = lane0;
    i01 = 2'd0;
    if (lane1 < lane0) begin
      m01 = lane1;
      i01 = 2'd1;
    end
    m23 = lane2;
    i23 = 2'd2;
    if (lane3 < lane2) begin
      m23 = lane3;
      i23 = 2'd3;
    end
    min_val  = m01;
    min_lane = i01;
    if (m23 < m01) begin
      min_val  = m23;
      min_lane = i23;
    end
  end

endmodule

// File: rtl/x3_writeback_unit.sv
// Final write-back stage: register-file write select, Hi/Lo registers, min-SAD search tracker.
// Latency 1 cycle from X3 inputs to every output; no backpressure, one X3 record accepted per cycle.
// Optional WB_RETIRE_COUNT_EN adds a free-running count of cycles with WB_RegWrite set.
module x3_writeback_unit
  import wb_pkg::*;
#(
  parameter int SAD_GROUPS = 16,
  parameter int IDX_W      = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        X3_PCAdd4,
  input  logic [31:0]        X3_DataMemOut,
  input  logic [31:0]        X3_ALUOut,
  input  logic [63:0]        X3_MaddOut,
  input  logic [31:0]        X3_HiLoOut,
  input  logic [4:0]         X3_WriteRegCarry,
  input  logic               X3_MemToReg,
  input  logic               X3_Jal_Mux,
  input  logic               X3_SEL_Madd,
  input  logic               X3_HiLo_WB,
  input  logic               X3_RegWrite,
  input  logic               X3_WriteDataHi,
  input  logic               X3_WriteDataLo,
  input  logic [1:0]         X3_BitsIn,
  input  logic [31:0]        X3_sad_add_b0_out,
  input  logic [31:0]        X3_sad_add_b1_out,
  input  logic [31:0]        X3_sad_add_b2_out,
  input  logic [31:0]        X3_sad_add_b3_out,
  input  logic               X3_minRegWrite,
  input  logic               SadClear,
  output logic [4:0]         WB_WriteReg,
  output logic [31:0]        WB_WriteData,
  output logic               WB_RegWrite,
  output logic [31:0]        Hi,
  output logic [31:0]        Lo,
  output logic [31:0]        MinSAD,
  output logic [IDX_W-1:0]   MinIndex,
  output logic               MinDone
`ifdef WB_RETIRE_COUNT_EN
  , output logic [31:0]      RetireCount
`endif
);

  localparam int GRP_W = (SAD_GROUPS > 1) ? $clog2(SAD_GROUPS) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(SAD_GROUPS - 1);

  logic [4:0]       wb_reg_q, wb_reg_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_we_q, wb_we_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      min_sad_q, min_sad_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic             done_q, done_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  sad_state_e       state_q, state_d;

  logic [31:0]      load_fmt;
  logic [31:0]      lane_min;
  logic [1:0]       lane_sel;
  logic [31:0]      base_sad;
  logic [IDX_W-1:0] base_idx;
  logic [GRP_W-1:0] grp_cur;
  logic [IDX_W-1:0] cand_idx;

  sad_min4 u_sad_min4 (
    .lane0    (X3_sad_add_b0_out),
    .lane1    (X3_sad_add_b1_out),
    .lane2    (X3_sad_add_b2_out),
    .lane3    (X3_sad_add_b3_out),
    .min_val  (lane_min),
    .min_lane (lane_sel)
  );

  // Register-file write: format loads, apply JAL > HiLo > load > ALU priority, squash writes to r0.
  always_comb begin
    case (X3_BitsIn)
      BITS_HALF: load_fmt = {{16{X3_DataMemOut[15]}}, X3_DataMemOut[15:0]};
      BITS_BYTE: load_fmt = {{24{X3_DataMemOut[7]}}, X3_DataMemOut[7:0]};
      BITS_WORD: load_fmt = X3_DataMemOut;
      default:   load_fmt = X3_DataMemOut;
    endcase
    wb_reg_d  = X3_WriteRegCarry;
    wb_data_d = X3_ALUOut;
    if (X3_Jal_Mux) begin
      wb_data_d = X3_PCAdd4;
      wb_reg_d  = JAL_REG;
    end else if (X3_HiLo_WB) begin
      wb_data_d = X3_HiLoOut;
    end else if (X3_MemToReg) begin
      wb_data_d = load_fmt;
    end
    wb_we_d = X3_RegWrite;
    if (X3_WriteRegCarry == 5'd0) begin
      wb_we_d   = 1'b0;
      wb_data_d = 32'd0;
    end
  end

  // Hi/Lo: madd/mult results when SEL_Madd, otherwise mthi/mtlo from the ALU.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (X3_SEL_Madd) begin
      if (X3_WriteDataHi) hi_d = X3_MaddOut[63:32];
      if (X3_WriteDataLo) lo_d = X3_MaddOut[31:0];
    end else begin
      if (X3_WriteDataHi) hi_d = X3_ALUOut;
      if (X3_WriteDataLo) lo_d = X3_ALUOut;
    end
  end

  // Min-SAD search. A group arriving outside SCAN starts a fresh search from the seed value,
  // so a new search may begin in the same cycle the DONE pulse is showing.
  always_comb begin
    base_sad  = (state_q == SCAN) ? min_sad_q : SAD_INIT;
    base_idx  = (state_q == SCAN) ? min_idx_q : '0;
    grp_cur   = (state_q == SCAN) ? grp_q : '0;
    cand_idx  = IDX_W'({grp_cur, lane_sel});
    state_d   = state_q;
    grp_d     = grp_q;
    min_sad_d = min_sad_q;
    min_idx_d = min_idx_q;
    done_d    = 1'b0;
    if (SadClear) begin
      state_d   = IDLE;
      grp_d     = '0;
      min_sad_d = SAD_INIT;
      min_idx_d = '0;
    end else if (X3_minRegWrite) begin
      // Earlier candidates already hold lower indices, so only strictly smaller lanes replace.
      if (lane_min < base_sad) begin
        min_sad_d = lane_min;
        min_idx_d = cand_idx;
      end else begin
        min_sad_d = base_sad;
        min_idx_d = base_idx;
      end
      if (grp_cur == GRP_LAST) begin
        state_d = DONE;
        grp_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = SCAN;
        grp_d   = grp_cur + GRP_W'(1);
      end
    end else if (state_q != SCAN) begin
      state_d = IDLE;
    end
  end

  // All stage state, including the FSM and its registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      min_sad_q <= SAD_INIT;
      min_idx_q <= '0;
      done_q    <= 1'b0;
      grp_q     <= '0;
      state_q   <= IDLE;
    end else begin
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
      done_q    <= done_d;
      grp_q     <= grp_d;
      state_q   <= state_d;
    end
  end

  assign WB_WriteReg  = wb_reg_q;
  assign WB_WriteData = wb_data_q;
  assign WB_RegWrite  = wb_we_q;
  assign Hi           = hi_q;
  assign Lo           = lo_q;
  assign MinSAD       = min_sad_q;
  assign MinIndex     = min_idx_q;
  assign MinDone      = done_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_q, retire_d;

  // Count cycles with a retiring register write; wraps naturally, ignores SadClear.
  always_comb begin
    retire_d = retire_q + {31'd0, wb_we_q};
  end

  // Retire counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign RetireCount = retire_q;
`endif

endmodule

// File: doc/x3_writeback_unit.md
Name: x3_writeback_unit

Overview:
Consumer end of the X2/X3 pipeline register, and the final write-back stage of the processor.
- Takes X3-stage fields and selects/formats the register-file write.
- Owns the architectural Hi/Lo registers.
- Runs a min-SAD tracker over the four SAD lane results, producing best-match value and index per search.
- All outputs registered; feeds the register file and the forwarding unit.

Parameters:
- SAD_GROUPS, 16, number of 4-lane SAD groups per search (candidates = 4*SAD_GROUPS).
- IDX_W, 8, width of MinIndex; must satisfy 2**IDX_W >= 4*SAD_GROUPS.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- X3_PCAdd4  in  32  return address for JAL
- X3_DataMemOut  in  32  load data
- X3_ALUOut  in  32  ALU result
- X3_MaddOut  in  64  madd/mult result {hi,lo}
- X3_HiLoOut  in  32  mfhi/mflo data
- X3_WriteRegCarry  in  5  destination register
- X3_MemToReg, X3_Jal_Mux, X3_SEL_Madd, X3_HiLo_WB, X3_RegWrite, X3_WriteDataHi, X3_WriteDataLo  in  1 each  controls
- X3_BitsIn  in  2  load width
- X3_sad_add_b0_out..X3_sad_add_b3_out  in  32 each  SAD lanes
- X3_minRegWrite  in  1  SAD group valid
- SadClear  in  1  abort/restart search
- WB_WriteReg  out  5  regfile address
- WB_WriteData  out  32  regfile data
- WB_RegWrite  out  1  regfile write enable
- Hi, Lo  out  32 each  architectural Hi/Lo
- MinSAD  out  32  best SAD so far
- MinIndex  out  IDX_W  candidate index of MinSAD
- MinDone  out  1  one-cycle pulse, search complete

Behaviour:
- Reset (async): every output 0; MinSAD = 32'hFFFF_FFFF; FSM = IDLE; group counter 0.
- WB latency 1: all WB_* outputs registered one cycle after X3 inputs.
- Data select priority:
  - X3_Jal_Mux: data = X3_PCAdd4; reg = 31.
  - else X3_HiLo_WB: data = X3_HiLoOut.
  - else X3_MemToReg: data = formatted X3_DataMemOut.
  - else data = X3_ALUOut.
- Load formatting by X3_BitsIn:
  - 00: word.
  - 01: sign-extended [15:0].
  - 10: sign-extended [7:0].
  - 11: word.
- WB_RegWrite = X3_RegWrite. If X3_WriteRegCarry == 0, WB_RegWrite = 0 and WB_WriteData = 0.
- Hi/Lo update on clock edge:
  - X3_SEL_Madd = 1: Hi <= MaddOut[63:32] if X3_WriteDataHi; Lo <= MaddOut[31:0] if X3_WriteDataLo.
  - X3_SEL_Madd = 0: flagged register <= X3_ALUOut (mthi/mtlo).
- Min-SAD FSM:
  - IDLE: first X3_minRegWrite -> SCAN, processing that group.
  - SCAN: each X3_minRegWrite cycle compares 4 lanes plus current MinSAD (unsigned). Strictly-less replaces. Ties keep the lower index; lane b0 is lowest. Candidate index = group*4 + lane. Group counter increments per valid cycle.
  - Last group (counter == SAD_GROUPS-1) -> DONE.
  - DONE: MinDone = 1 for exactly one cycle, then IDLE. MinSAD/MinIndex hold until the next search's first group, which reloads MinSAD to 32'hFFFF_FFFF before comparing.
  - X3_minRegWrite low in SCAN: hold state; gaps are allowed.
- SadClear (synchronous, any state): FSM -> IDLE, counter 0, MinSAD = all-ones, MinIndex 0, no MinDone. Wins over a simultaneous X3_minRegWrite, whose group is discarded.
- Reset mid-search: full reinit; no MinDone pulse.
- Lane value 32'hFFFF_FFFF never replaces the initial MinSAD.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
  - Defined: adds output RetireCount (32), which increments on every cycle WB_RegWrite is 1. It wraps 32'hFFFF_FFFF -> 0, resets to 0 and is unaffected by SadClear.
  - Undefined: port and counter are absent; all other behaviour identical.

Decomposition:
- Package wb_pkg holds:
  - BitsIn encodings BITS_WORD/BITS_HALF/BITS_BYTE.
  - JAL_REG = 5'd31.
  - SAD_INIT = 32'hFFFF_FFFF.
  - FSM state codes IDLE/SCAN/DONE.
- Sub-module sad_min4: combinational 4-lane minimum plus lane index, with lower-lane tie-break. Instanced once.

Test Plan:
- JAL with PCAdd4 = 0x0000_0404, RegWrite = 1 -> next cycle WB_WriteReg = 31, WB_WriteData = 0x404, WB_RegWrite = 1.
- MemToReg, DataMemOut = 0x1234_8086: BitsIn = 10 -> 0xFFFF_FF86; BitsIn = 01 -> 0xFFFF_8086; BitsIn = 00 -> 0x1234_8086.
- SEL_Madd with MaddOut = 0x0000_0001_FFFF_FFFE and both write flags -> Hi = 1, Lo = 0xFFFF_FFFE; with only WriteDataLo set, Hi is unchanged.
- SAD_GROUPS = 2:
  - Group 0 lanes {50,20,20,90}, then a 3-cycle gap, then group 1 lanes {30,20,5,5}.
  - Required: MinSAD = 5, MinIndex = 6, MinDone high for exactly one cycle after group 1.
- SadClear asserted with group 1 -> no MinDone; a new search starts cleanly and returns the correct min.
- Reset asserted asynchronously mid-SCAN -> outputs 0 and MinSAD = 0xFFFF_FFFF immediately, without waiting for Clk. RegWrite with WriteRegCarry = 0 -> WB_RegWrite = 0.
